// File: rtl/dm_bus_slave.sv
// dm_bus_slave: data-memory responder for CPU load/store traffic.
// Valid/ready request and response channels, with a fixed access latency.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            00 word, 01 half, 10 byte, 11 illegal
//   req_sign            loads: 1 sign-extend, 0 zero-extend
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            misaligned, out-of-range or illegal-size access
module dm_bus_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Request fields captured at acceptance
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    // ------------------------------------------------------------
    // Access selection.
    // With LATENCY=1 the memory action happens on the accept edge
    // itself, so the live request fields are used while IDLE;
    // otherwise the captured copy drives the access.
    // ------------------------------------------------------------
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size;
    logic        acc_sign;
    logic [31:0] acc_wdata;
    logic        accept;
    logic        enter_resp;

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_size  = req_size;
            acc_sign  = req_sign;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_sign  = sign_q;
            acc_wdata = wdata_q;
        end
    end

    assign accept     = (state_q == S_IDLE) && req_valid;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // ------------------------------------------------------------
    // Address decode and error detection
    // ------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [31:0]           addr_hi;
    logic                  acc_err;

    assign idx     = acc_addr[ADDR_WIDTH+1:2];
    assign lane    = acc_addr[1:0];
    assign addr_hi = acc_addr >> (ADDR_WIDTH + 2);

    always_comb begin
        acc_err = 1'b0;
        if (acc_size == 2'b11) begin
            acc_err = 1'b1;
        end
        if ((acc_size == SZ_HALF) && lane[0]) begin
            acc_err = 1'b1;
        end
        if ((acc_size == SZ_WORD) && (lane != 2'b00)) begin
            acc_err = 1'b1;
        end
        if (addr_hi != 32'd0) begin
            acc_err = 1'b1;
        end
    end

    // ------------------------------------------------------------
    // Load path: lane select then extension
    // ------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] ld_data;

    assign rd_word = mem_q[idx];
    assign byte_sh = rd_word >> {lane, 3'b000};
    assign half_sh = rd_word >> {lane[1], 4'b0000};

    always_comb begin
        ld_data = 32'd0;
        case (acc_size)
            SZ_WORD: ld_data = rd_word;
            SZ_HALF: ld_data = {{16{acc_sign & half_sh[15]}}, half_sh[15:0]};
            SZ_BYTE: ld_data = {{24{acc_sign & byte_sh[7]}}, byte_sh[7:0]};
            default: ld_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------
    // Store path: lane mask and aligned data, merged with old word
    // ------------------------------------------------------------
    logic [31:0] st_mask;
    logic [31:0] st_data;
    logic [31:0] st_word;

    always_comb begin
        st_mask = 32'd0;
        st_data = 32'd0;
        case (acc_size)
            SZ_WORD: begin
                st_mask = 32'hFFFF_FFFF;
                st_data = acc_wdata;
            end
            SZ_HALF: begin
                st_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                st_data = {16'd0, acc_wdata[15:0]} << {lane[1], 4'b0000};
            end
            SZ_BYTE: begin
                st_mask = 32'h0000_00FF << {lane, 3'b000};
                st_data = {24'd0, acc_wdata[7:0]} << {lane, 3'b000};
            end
            default: begin
                st_mask = 32'd0;
                st_data = 32'd0;
            end
        endcase
    end

    assign st_word = (rd_word & ~st_mask) | (st_data & st_mask);

    // ------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY <= 1) begin
                        state_d = S_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // ------------------------------------------------------------
    // Request capture and response registers
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                size_q  <= req_size;
                sign_q  <= req_sign;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_we) ? 32'd0 : ld_data;
            end else if ((state_q == S_RESP) && resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------
    // Memory array; stores commit on the edge entering RESP
    // ------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (enter_resp && acc_we && !acc_err) begin
            mem_q[idx] <= st_word;
        end
    end

endmodule

// File: tb/tb_dm_bus_slave.sv
// tb_dm_bus_slave: scoreboard bench for dm_bus_slave.
// Directed load/store vectors with hand-computed responses.
module tb_dm_bus_slave;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dm_bus_slave #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response handshake
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rdata %h err %0b expected none",
                         resp_rdata, resp_err);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk({e.nm, ".rdata"}, resp_rdata, e.rdata);
                chk({e.nm, ".err"}, {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s.req_ready_timeout: got 0 expected 1", nm);
        end
    endtask

    task automatic do_req(input string nm, input logic we,
                          input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int k;
        exp_t e;
        wait_ready(nm);
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_sign  = sign;
        req_wdata = wdata;
        req_valid = 1'b1;
        e.nm      = nm;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        expq.push_back(e);
        tick();
        // Scramble request fields: the in-flight access must not see them
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFF;
        req_size  = 2'b11;
        req_sign  = ~sign;
        req_wdata = ~wdata;
        k = 1;
        while (!resp_valid && k < 20) begin
            tick();
            k++;
        end
        chk({nm, ".latency"}, 32'(k), 32'(LAT));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Word store / load
        do_req("sw10", 1'b1, 32'h10, 2'b00, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        do_req("lw10", 1'b0, 32'h10, 2'b00, 1'b0, 32'd0, 32'h1234_5678, 1'b0);

        // Byte store, signed/unsigned byte loads
        do_req("sb11", 1'b1, 32'h11, 2'b10, 1'b0, 32'h0000_00AB, 32'd0, 1'b0);
        do_req("lb11", 1'b0, 32'h11, 2'b10, 1'b1, 32'd0, 32'hFFFF_FFAB, 1'b0);
        do_req("lbu11", 1'b0, 32'h11, 2'b10, 1'b0, 32'd0, 32'h0000_00AB, 1'b0);
        do_req("lw10b", 1'b0, 32'h10, 2'b00, 1'b0, 32'd0, 32'h1234_AB78, 1'b0);
        do_req("lbu13", 1'b0, 32'h13, 2'b10, 1'b0, 32'd0, 32'h0000_0012, 1'b0);

        // Halfword store / loads
        do_req("sh22", 1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_8001, 32'd0, 1'b0);
        do_req("lh22", 1'b0, 32'h22, 2'b01, 1'b1, 32'd0, 32'hFFFF_8001, 1'b0);
        do_req("lhu22", 1'b0, 32'h22, 2'b01, 1'b0, 32'd0, 32'h0000_8001, 1'b0);
        do_req("lw20", 1'b0, 32'h20, 2'b00, 1'b0, 32'd0, 32'h8001_0000, 1'b0);
        do_req("lh20", 1'b0, 32'h20, 2'b01, 1'b1, 32'd0, 32'h0000_0000, 1'b0);

        // Error cases
        do_req("lw13", 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
        do_req("sh21", 1'b1, 32'h21, 2'b01, 1'b0, 32'h0000_FFFF, 32'd0, 1'b1);
        do_req("sw1000", 1'b1, 32'h1000, 2'b00, 1'b0, 32'hCAFE_F00D, 32'd0, 1'b1);
        do_req("sz11st", 1'b1, 32'h20, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        do_req("sz11ld", 1'b0, 32'h10, 2'b11, 1'b1, 32'd0, 32'd0, 1'b1);
        do_req("lw000", 1'b0, 32'h0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
        do_req("lw20b", 1'b0, 32'h20, 2'b00, 1'b0, 32'd0, 32'h8001_0000, 1'b0);
        do_req("lw10c", 1'b0, 32'h10, 2'b00, 1'b0, 32'd0, 32'h1234_AB78, 1'b0);

        // Backpressure: response held, new requests ignored
        begin
            exp_t e;
            int   k;
            tick();
            resp_ready = 1'b0;
            wait_ready("bp");
            req_we    = 1'b0;
            req_addr  = 32'h10;
            req_size  = 2'b00;
            req_sign  = 1'b0;
            req_valid = 1'b1;
            e.nm      = "bp_lw10";
            e.rdata   = 32'h1234_AB78;
            e.err     = 1'b0;
            expq.push_back(e);
            tick();
            req_we    = 1'b1;
            req_addr  = 32'h40;
            req_size  = 2'b00;
            req_wdata = 32'h0000_0055;
            k = 1;
            while (!resp_valid && k < 20) begin
                tick();
                k++;
            end
            chk("bp.latency", 32'(k), 32'(LAT));
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("bp.resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("bp.resp_rdata", resp_rdata, 32'h1234_AB78);
                chk("bp.req_ready", {31'd0, req_ready}, 32'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            tick();
            chk("bp.idle_req_ready", {31'd0, req_ready}, 32'd1);
            chk("bp.idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        do_req("lw40", 1'b0, 32'h40, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);

        // Reset during WAIT of a store aborts it
        wait_ready("rstw");
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rstw.wait_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rstw.wait_resp_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;
        tick();
        chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw.resp_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b0;
        tick();
        do_req("lw30", 1'b0, 32'h30, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
        do_req("lw10r", 1'b0, 32'h10, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);

        // Drain scoreboard
        begin
            int w;
            w = 0;
            while (expq.size() != 0 && w < 20) begin
                tick();
                w++;
            end
            chk("drain.pending", 32'(expq.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
